// File: rtl/huff_decode_ctrl.sv
// JPEG Huffman decode sequencer: walks table 1/table 2 per code bit and emits (run, coefficient) records.
// Optional build macro COEF_EXTEND_EN applies the JPEG sign-extend rule to coeff_s1.
module huff_decode_ctrl #(
  parameter int MAX_LEN   = 8,
  parameter int BLK_COEFS = 64
) (
  input  logic        phi2,
  input  logic        reset_s1,
  input  logic        start_s1,
  input  logic        bitstream_s1,
  input  logic        bit_valid_s1,
  output logic        bit_ready_s1,
  output logic [3:0]  t1_addr_s1,
  input  logic [8:0]  maxcode_v1,
  input  logic [5:0]  base_v1,
  output logic [5:0]  t2_addr_s1,
  input  logic [1:0]  run_length_v1,
  input  logic [3:0]  coeff_size_v1,
  output logic        coeff_valid_s1,
  output logic [1:0]  run_s1,
  output logic [11:0] coeff_s1,
  output logic        eob_s1,
  output logic        err_s1
);

  localparam logic [3:0] LEN_LAST = 4'(MAX_LEN);
  localparam logic [7:0] POS_LAST = 8'(BLK_COEFS);

  typedef enum logic [2:0] {IDLE, SHIFT, CMP, LOOK2, COEF, EMIT, ERROR} state_t;

  state_t      state, state_next;
  logic [7:0]  code;
  logic [3:0]  len;
  logic [6:0]  pos;
  logic        dc;
  logic [1:0]  run;
  logic [3:0]  cnt;
  logic [10:0] raw;
  logic        xfer, code_match, eob_sym, block_done;
  logic [7:0]  pos_next;
  logic [11:0] coeff_value;

  assign xfer = bit_valid_s1 && bit_ready_s1;

  always_comb begin
    pos_next   = {1'b0, pos} + (dc ? 8'd1 : ({6'd0, run} + 8'd1));
    block_done = pos_next >= POS_LAST;
    code_match = !maxcode_v1[8] && (code <= maxcode_v1[7:0]);
    eob_sym    = !dc && (run_length_v1 == 2'd0) && (coeff_size_v1 == 4'd0);
  end

`ifdef COEF_EXTEND_EN
  logic [3:0]  size;
  logic [11:0] raw_ext, span, half;

  // A clear top magnitude bit means a negative value: subtract 2^S - 1.
  always_comb begin
    raw_ext     = {1'b0, raw};
    span        = (12'd1 << size) - 12'd1;
    half        = (12'd1 << size) >> 1;
    coeff_value = ((raw_ext & half) == 12'd0) ? (raw_ext - span) : raw_ext;
  end
`else
  assign coeff_value = {1'b0, raw};
`endif

  always_ff @(posedge phi2) begin
    if (reset_s1) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bit_ready_s1   = 1'b0;
    coeff_valid_s1 = 1'b0;
    eob_s1         = 1'b0;
    err_s1         = 1'b0;
    run_s1         = '0;
    coeff_s1       = '0;
    case (state)
      IDLE: if (start_s1) state_next = SHIFT;
      SHIFT: begin
        bit_ready_s1 = 1'b1;
        if (bit_valid_s1) state_next = CMP;
      end
      CMP: begin
        if (code_match)             state_next = LOOK2;
        else if (len >= LEN_LAST)   state_next = ERROR;
        else                        state_next = SHIFT;
      end
      LOOK2: begin
        if (eob_sym) begin
          eob_s1     = 1'b1;
          state_next = IDLE;
        end else if (coeff_size_v1 == 4'd0) begin
          state_next = EMIT;
        end else begin
          state_next = COEF;
        end
      end
      COEF: begin
        bit_ready_s1 = 1'b1;
        if (bit_valid_s1 && cnt <= 4'd1) state_next = EMIT;
      end
      EMIT: begin
        coeff_valid_s1 = 1'b1;
        run_s1         = run;
        coeff_s1       = coeff_value;
        if (block_done) begin
          eob_s1     = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = SHIFT;
        end
      end
      ERROR: begin
        err_s1 = 1'b1;
        if (start_s1) state_next = SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Table addresses are registered; the tables answer combinationally from them in the next state.
  always_ff @(posedge phi2) begin
    if (reset_s1) begin
      code       <= '0;
      len        <= '0;
      pos        <= '0;
      dc         <= 1'b0;
      run        <= '0;
      cnt        <= '0;
      raw        <= '0;
      t1_addr_s1 <= '0;
      t2_addr_s1 <= '0;
`ifdef COEF_EXTEND_EN
      size       <= '0;
`endif
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start_s1) begin
            code <= '0;
            len  <= '0;
            pos  <= '0;
            dc   <= 1'b1;
          end
        end
        SHIFT: begin
          if (xfer) begin
            code       <= {code[6:0], bitstream_s1};
            len        <= len + 4'd1;
            t1_addr_s1 <= {dc, len[2:0]};
          end
        end
        CMP: if (code_match) t2_addr_s1 <= base_v1 + code[5:0];
        LOOK2: begin
          run <= run_length_v1;
          cnt <= coeff_size_v1;
          raw <= '0;
`ifdef COEF_EXTEND_EN
          size <= coeff_size_v1;
`endif
        end
        COEF: begin
          if (xfer) begin
            raw <= {raw[9:0], bitstream_s1};
            cnt <= cnt - 4'd1;
          end
        end
        EMIT: begin
          pos  <= pos_next[6:0];
          dc   <= 1'b0;
          code <= '0;
          len  <= '0;
        end
        default: ;
      endcase
      if (state_next == IDLE) begin
        t1_addr_s1 <= '0;
        t2_addr_s1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_huff_decode_ctrl.sv
// Self-checking bench for huff_decode_ctrl: directed scenarios plus random tables/bitstreams
// checked against an algorithmic block decoder. Honours COEF_EXTEND_EN like the design.
module tb_huff_decode_ctrl;

  logic        phi2 = 1'b0;
  logic        reset_s1, start_s1, bitstream_s1, bit_valid_s1;
  logic        bit_ready_s1, coeff_valid_s1, eob_s1, err_s1;
  logic [3:0]  t1_addr_s1;
  logic [5:0]  t2_addr_s1;
  logic [8:0]  maxcode_v1;
  logic [5:0]  base_v1;
  logic [1:0]  run_length_v1, run_s1;
  logic [3:0]  coeff_size_v1;
  logic [11:0] coeff_s1;

  logic [8:0] mc  [16];
  logic [5:0] bs  [16];
  logic [1:0] t2r [64];
  logic [3:0] t2s [64];

  typedef struct {
    int          cyc;
    logic        cv;
    logic        eob;
    logic [1:0]  run;
    logic [11:0] val;
  } ev_t;

  ev_t  evq[$];
  ev_t  expq[$];
  int   acc_cyc[$];
  bit   bq[$];
  bit   rb[4096];
  int   cyc = 0;
  int   err_cyc;
  int   n_checks = 0;
  int   n_errors = 0;

  wire [27:0] all_outs = {bit_ready_s1, coeff_valid_s1, eob_s1, err_s1,
                          t1_addr_s1, t2_addr_s1, run_s1, coeff_s1};

  assign maxcode_v1    = mc[t1_addr_s1];
  assign base_v1       = bs[t1_addr_s1];
  assign run_length_v1 = t2r[t2_addr_s1];
  assign coeff_size_v1 = t2s[t2_addr_s1];

  huff_decode_ctrl dut (
    .phi2(phi2), .reset_s1(reset_s1), .start_s1(start_s1),
    .bitstream_s1(bitstream_s1), .bit_valid_s1(bit_valid_s1), .bit_ready_s1(bit_ready_s1),
    .t1_addr_s1(t1_addr_s1), .maxcode_v1(maxcode_v1), .base_v1(base_v1),
    .t2_addr_s1(t2_addr_s1), .run_length_v1(run_length_v1), .coeff_size_v1(coeff_size_v1),
    .coeff_valid_s1(coeff_valid_s1), .run_s1(run_s1), .coeff_s1(coeff_s1),
    .eob_s1(eob_s1), .err_s1(err_s1)
  );

  always #5 phi2 = ~phi2;
  always @(posedge phi2) cyc <= cyc + 1;

  // JPEG magnitude-category value of an S-bit raw field.
  function automatic logic [11:0] exp_coef(input int raw, input int s);
    int v;
    v = raw;
`ifdef COEF_EXTEND_EN
    if (s > 0 && raw < (1 << (s - 1))) v = raw - ((1 << s) - 1);
`endif
    return 12'(v);
  endfunction

  task automatic do_reset();
    @(negedge phi2);
    reset_s1 = 1'b1; start_s1 = 1'b0; bit_valid_s1 = 1'b0; bitstream_s1 = 1'b0;
    repeat (2) @(negedge phi2);
    reset_s1 = 1'b0;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 16; i++) begin mc[i] = 9'h100; bs[i] = 6'd0; end
    for (int i = 0; i < 64; i++) begin t2r[i] = 2'd0; t2s[i] = 4'd0; end
  endtask

  // DC code "10" (length 2) -> table 2 entry 7 = {run 0, size 3}
  task automatic set_dc_table();
    clear_tables();
    mc[9] = 9'h002; bs[9] = 6'h05;
    t2r[7] = 2'd0; t2s[7] = 4'd3;
  endtask

  task automatic pulse_start();
    @(negedge phi2);
    start_s1 = 1'b1; bit_valid_s1 = 1'b0;
  endtask

  // Runs exactly ncycles cycles, feeding bq on demand and logging accepts and output events.
  task automatic drive(input int ncycles, input int valid_pct, input int stall_at, input int stall_len);
    int   acc = 0;
    int   stalled = 0;
    ev_t  x;
    evq.delete(); acc_cyc.delete(); err_cyc = -1;
    for (int n = 0; n < ncycles; n++) begin
      @(negedge phi2);
      start_s1 = 1'b0;
      if (coeff_valid_s1 || eob_s1) begin
        x.cyc = cyc; x.cv = coeff_valid_s1; x.eob = eob_s1; x.run = run_s1; x.val = coeff_s1;
        evq.push_back(x);
      end
      if (err_s1 && err_cyc < 0) err_cyc = cyc;
      if (!bit_ready_s1) begin
        bit_valid_s1 = 1'($urandom_range(1));
        bitstream_s1 = 1'($urandom_range(1));
      end else if (bq.size() == 0 || (acc == stall_at && stalled < stall_len)) begin
        if (bq.size() != 0) stalled++;
        bit_valid_s1 = 1'b0;
      end else if (int'($urandom_range(99)) < valid_pct) begin
        bit_valid_s1 = 1'b1;
        bitstream_s1 = bq.pop_front();
        acc_cyc.push_back(cyc);
        acc++;
      end else begin
        bit_valid_s1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (all_outs !== 28'd0) begin
      n_errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs);
    end
    set_dc_table();
    pulse_start();
    bq = '{1'b1, 1'b0, 1'b1};
    drive(7, 100, -1, 0);
    n_checks++;
    if (bit_ready_s1 !== 1'b1) begin
      n_errors++; $display("[TB] FAIL mid_coef_ready: got %b expected 1", bit_ready_s1);
    end
    reset_s1 = 1'b1; bit_valid_s1 = 1'b1; bitstream_s1 = 1'b1;
    repeat (3) @(negedge phi2);
    reset_s1 = 1'b0;
    n_checks++;
    if (all_outs !== 28'd0) begin
      n_errors++; $display("[TB] FAIL reset_mid_coef_outputs: got %h expected 0", all_outs);
    end
    @(negedge phi2);
    n_checks++;
    if (all_outs !== 28'd0) begin
      n_errors++; $display("[TB] FAIL after_reset_idle: got %h expected 0", all_outs);
    end
  endtask

  task automatic run_dc(input bit b0, input bit b1, input bit b2, input int raw,
                        input int stall_len, input string tag);
    do_reset();
    set_dc_table();
    pulse_start();
    bq = '{1'b1, 1'b0, b0, b1, b2};
    drive(14 + stall_len, 100, (stall_len > 0) ? 3 : -1, stall_len);
    n_checks++;
    if (evq.size() != 1) begin
      n_errors++; $display("[TB] FAIL %s_events: got %0d expected 1", tag, evq.size());
    end else begin
      n_checks++;
      if ({evq[0].cv, evq[0].eob, evq[0].run, evq[0].val} !== {1'b1, 1'b0, 2'd0, exp_coef(raw, 3)}) begin
        n_errors++;
        $display("[TB] FAIL %s_record: got cv%b eob%b run%0d val%h expected val%h", tag,
                 evq[0].cv, evq[0].eob, evq[0].run, evq[0].val, exp_coef(raw, 3));
      end
      n_checks++;
      if (evq[0].cyc - acc_cyc[0] + 1 != 9 + stall_len) begin
        n_errors++;
        $display("[TB] FAIL %s_latency: got %0d expected %0d", tag,
                 evq[0].cyc - acc_cyc[0] + 1, 9 + stall_len);
      end
    end
    n_checks++;
    if (t2_addr_s1 !== 6'd7) begin
      n_errors++; $display("[TB] FAIL %s_t2_addr: got %0d expected 7", tag, t2_addr_s1);
    end
  endtask

  task automatic test_dc_symbol();
    run_dc(1'b1, 1'b0, 1'b1, 5, 0, "dc_pos");
  endtask

  task automatic test_dc_negative();
    run_dc(1'b0, 1'b1, 1'b0, 2, 0, "dc_neg");
  endtask

  task automatic test_stall();
    run_dc(1'b1, 1'b0, 1'b1, 5, 5, "stall");
  endtask

  task automatic test_ac_eob();
    do_reset();
    set_dc_table();
    mc[0] = 9'h000; bs[0] = 6'd20;
    pulse_start();
    bq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    drive(20, 100, -1, 0);
    n_checks++;
    if (evq.size() != 2) begin
      n_errors++; $display("[TB] FAIL eob_events: got %0d expected 2", evq.size());
    end else begin
      n_checks++;
      if ({evq[1].cv, evq[1].eob} !== 2'b01) begin
        n_errors++; $display("[TB] FAIL eob_pulse: got cv%b eob%b expected cv0 eob1", evq[1].cv, evq[1].eob);
      end
      n_checks++;
      if (evq[1].cyc != acc_cyc[5] + 2) begin
        n_errors++; $display("[TB] FAIL eob_timing: got %0d expected %0d", evq[1].cyc, acc_cyc[5] + 2);
      end
    end
    n_checks++;
    if (all_outs !== 28'd0) begin
      n_errors++; $display("[TB] FAIL eob_idle_outputs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_no_match();
    do_reset();
    clear_tables();
    pulse_start();
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(1'($urandom_range(1)));
    drive(40, 100, -1, 0);
    n_checks++;
    if (acc_cyc.size() != 8 || bq.size() != 4) begin
      n_errors++; $display("[TB] FAIL nomatch_bits: got %0d accepted expected 8", acc_cyc.size());
    end
    n_checks++;
    if (acc_cyc.size() == 0 || err_cyc - acc_cyc[0] != 2 * 8) begin
      n_errors++; $display("[TB] FAIL nomatch_err_timing: got err at %0d", err_cyc);
    end
    n_checks++;
    if ({err_s1, bit_ready_s1} !== 2'b10) begin
      n_errors++; $display("[TB] FAIL nomatch_err_level: got err%b rdy%b expected err1 rdy0", err_s1, bit_ready_s1);
    end
    start_s1 = 1'b1; bit_valid_s1 = 1'b0;
    @(negedge phi2);
    start_s1 = 1'b0;
    n_checks++;
    if ({err_s1, bit_ready_s1} !== 2'b01) begin
      n_errors++; $display("[TB] FAIL nomatch_restart: got err%b rdy%b expected err0 rdy1", err_s1, bit_ready_s1);
    end
  endtask

  task automatic test_block_fill();
    ev_t e;
    bit  b;
    do_reset();
    set_dc_table();
    mc[0] = 9'h000; bs[0] = 6'd30; t2r[30] = 2'd2; t2s[30] = 4'd1;
    bq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    expq.delete();
    e.cyc = 0; e.cv = 1'b1; e.eob = 1'b0; e.run = 2'd0; e.val = exp_coef(5, 3);
    expq.push_back(e);
    for (int k = 0; k < 21; k++) begin
      b = 1'($urandom_range(1));
      bq.push_back(1'b0); bq.push_back(b);
      e.run = 2'd2; e.val = exp_coef(int'(b), 1); e.eob = (1 + 3 * (k + 1) >= 64);
      expq.push_back(e);
    end
    bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b1);
    pulse_start();
    drive(400, 80, -1, 0);
    n_checks++;
    if (evq.size() != expq.size()) begin
      n_errors++; $display("[TB] FAIL fill_events: got %0d expected %0d", evq.size(), expq.size());
    end else begin
      for (int i = 0; i < evq.size(); i++) begin
        n_checks++;
        if ({evq[i].cv, evq[i].eob, evq[i].run, evq[i].val} !==
            {expq[i].cv, expq[i].eob, expq[i].run, expq[i].val}) begin
          n_errors++;
          $display("[TB] FAIL fill_record%0d: got cv%b eob%b run%0d val%h expected cv%b eob%b run%0d val%h", i,
                   evq[i].cv, evq[i].eob, evq[i].run, evq[i].val,
                   expq[i].cv, expq[i].eob, expq[i].run, expq[i].val);
        end
      end
    end
    n_checks++;
    if (bq.size() != 3 || bit_ready_s1 !== 1'b0) begin
      n_errors++; $display("[TB] FAIL fill_stop: got %0d bits left rdy%b expected 3 rdy0", bq.size(), bit_ready_s1);
    end
  endtask

  // Reference decoder: walks the bit array by the table rules and queues the expected records.
  task automatic model_block(input int start, output int nbits);
    int   i, pos, code, mlen, raw, a, r, s;
    bit   dc, found;
    logic [8:0] e;
    ev_t  x;
    i = start; dc = 1'b1; pos = 0; x.cyc = 0;
    forever begin
      code = 0; found = 1'b0; mlen = 0;
      for (int l = 1; l <= 8 && !found; l++) begin
        code = code * 2 + int'(rb[i]); i++;
        e = mc[4'({dc, 3'(l - 1)})];
        if (!e[8] && code <= int'(e[7:0])) begin found = 1'b1; mlen = l; end
      end
      if (!found) break;
      a = (int'(bs[4'({dc, 3'(mlen - 1)})]) + code) % 64;
      r = int'(t2r[a]); s = int'(t2s[a]);
      if (!dc && r == 0 && s == 0) begin
        x.cv = 1'b0; x.eob = 1'b1; x.run = 2'd0; x.val = 12'd0;
        expq.push_back(x);
        break;
      end
      raw = 0;
      for (int k = 0; k < s; k++) begin raw = raw * 2 + int'(rb[i]); i++; end
      pos += dc ? 1 : r + 1;
      x.cv = 1'b1; x.eob = (pos >= 64); x.run = 2'(r); x.val = exp_coef(raw, s);
      expq.push_back(x);
      dc = 1'b0;
      if (pos >= 64) break;
    end
    nbits = i - start;
  endtask

  task automatic test_random();
    int ptr, nb, idx;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int d = 0; d < 2; d++) begin
        for (int l = 1; l <= 8; l++) begin
          idx = d * 8 + l - 1;
          if (l == 8)                       mc[idx] = 9'h0FF;
          else if ($urandom_range(3) == 0)  mc[idx] = 9'h100;
          else                              mc[idx] = {1'b0, 8'($urandom_range((1 << l) - 1))};
          bs[idx] = 6'($urandom_range(63));
        end
      end
      for (int a = 0; a < 64; a++) begin
        t2r[a] = 2'($urandom_range(3));
        t2s[a] = 4'($urandom_range(11));
      end
      for (int i = 0; i < 4096; i++) rb[i] = 1'($urandom_range(1));
      ptr = 0;
      for (int blk = 0; blk < 2; blk++) begin
        expq.delete();
        model_block(ptr, nb);
        bq.delete();
        for (int i = 0; i < nb; i++) bq.push_back(rb[ptr + i]);
        ptr += nb;
        pulse_start();
        drive(nb * 4 + 300, 70, -1, 0);
        n_checks++;
        if (evq.size() != expq.size() || bq.size() != 0) begin
          n_errors++;
          $display("[TB] FAIL rand_r%0d_b%0d_events: got %0d events %0d bits left expected %0d events 0 left",
                   round, blk, evq.size(), bq.size(), expq.size());
        end else begin
          for (int i = 0; i < evq.size(); i++) begin
            n_checks++;
            if ({evq[i].cv, evq[i].eob, evq[i].run, evq[i].val} !==
                {expq[i].cv, expq[i].eob, expq[i].run, expq[i].val}) begin
              n_errors++;
              $display("[TB] FAIL rand_r%0d_b%0d_rec%0d: got cv%b eob%b run%0d val%h expected cv%b eob%b run%0d val%h",
                       round, blk, i, evq[i].cv, evq[i].eob, evq[i].run, evq[i].val,
                       expq[i].cv, expq[i].eob, expq[i].run, expq[i].val);
            end
          end
        end
        n_checks++;
        if (bit_ready_s1 !== 1'b0) begin
          n_errors++; $display("[TB] FAIL rand_r%0d_b%0d_idle: got rdy%b expected rdy0", round, blk, bit_ready_s1);
        end
      end
    end
  endtask

  initial begin
    reset_s1 = 1'b1; start_s1 = 1'b0; bit_valid_s1 = 1'b0; bitstream_s1 = 1'b0;
    clear_tables();
    $display("[TB] huff_decode_ctrl bench starting");
    test_reset();
    test_dc_symbol();
    test_dc_negative();
    test_ac_eob();
    test_no_match();
    test_stall();
    test_block_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/huff_decode_ctrl.md
# huff_decode_ctrl

Sequencing controller for the JPEG Huffman decode datapath. Once table initialization is complete (reset_s1 low), it consumes the serial bitstream one bit per accepted cycle and drives the table 1 (maxcode/base) and table 2 (run-length/size) read addresses. It then collects the coefficient magnitude bits and emits one decoded (run, coefficient) record per symbol, for one 8x8 block per start pulse.

## Interface
Parameters:
- MAX_LEN, 8: longest Huffman code in bits; table 1 holds MAX_LEN entries per DC/AC half.
- BLK_COEFS, 64: coefficient positions per block.

Ports:
- phi2  in  1  single clock; all state updates on posedge phi2.
- reset_s1  in  1  synchronous, active-high reset.
- start_s1  in  1  begin decoding a new block (DC symbol first); honoured only in IDLE or ERROR.
- bitstream_s1  in  1  next bitstream bit.
- bit_valid_s1  in  1  bitstream_s1 is valid this cycle.
- bit_ready_s1  out  1  controller accepts a bit this cycle; a transfer occurs when valid and ready are both high.
- t1_addr_s1  out  4  table 1 read address {dc_ac, len-1}; dc_ac = 1 for DC.
- maxcode_v1  in  9  table 1 data, valid one cycle after the address; bit 8 set means no codes of this length.
- base_v1  in  6  table 1 data: the value added to the code to form the table 2 address.
- t2_addr_s1  out  6  table 2 read address.
- run_length_v1  in  2  table 2 data, valid one cycle after the address.
- coeff_size_v1  in  4  table 2 data, legal range 0..11.
- coeff_valid_s1  out  1  one-cycle pulse; run_s1 and coeff_s1 are valid.
- run_s1  out  2  zero-run preceding the coefficient.
- coeff_s1  out  12  coefficient value, two's complement.
- eob_s1  out  1  one-cycle pulse: block finished, either by an EOB symbol or by position 63 being filled.
- err_s1  out  1  level: no code matched within MAX_LEN bits.

## Operation
States are IDLE, SHIFT, CMP, LOOK2, COEF, EMIT and ERROR.
- IDLE: all outputs 0. On start_s1: clear code, len, pos; set dc = 1; go to SHIFT.
- SHIFT: bit_ready_s1 = 1. On transfer: code <= {code[7:0], bit}; len <= len + 1; t1_addr_s1 <= {dc, len}; go to CMP.
- CMP: the code matches when !maxcode_v1[8] && code <= maxcode_v1[7:0].
  - On a match: t2_addr_s1 <= base_v1 + code[5:0] (mod 64); go to LOOK2.
  - On no match with len == MAX_LEN: go to ERROR.
  - Otherwise: go back to SHIFT.
- LOOK2: latch run and size from table 2.
  - AC symbol with run = 0 and size = 0: pulse eob_s1; go to IDLE.
  - size = 0 (any other case): value = 0; go to EMIT.
  - Otherwise: cnt <= size; go to COEF.
- COEF: bit_ready_s1 = 1. Shift bits MSB-first into raw; cnt decrements on each transfer. When cnt reaches 0, go to EMIT.
- EMIT:
  - Pulse coeff_valid_s1 with run_s1 and coeff_s1.
  - pos <= pos + (dc ? 1 : run + 1); then dc <= 0.
  - If the new pos >= BLK_COEFS: pulse eob_s1 in the same cycle and go to IDLE.
  - Otherwise: clear code and len; go to SHIFT.
- ERROR: err_s1 = 1 and bit_ready_s1 = 0. Leave only on reset_s1 or start_s1; start_s1 clears err_s1 and begins a new block.
- reset_s1 overrides every state: the next state is IDLE and every output is 0, including the t1/t2 addresses and err_s1.
- bit_valid_s1 is ignored whenever bit_ready_s1 is low.
- start_s1 is ignored in every state other than IDLE and ERROR.

## Timing
- Each code bit costs two cycles (SHIFT then CMP), not counting cycles where bit_valid_s1 is low.
- A code of length L with coefficient size S, with bits always valid, produces coeff_valid_s1 exactly 2L + 1 + S + 1 cycles after its first bit is accepted.
  - Example: L = 2, S = 3 gives 9 cycles.
- eob_s1 for an EOB symbol fires in the LOOK2 cycle, with no coeff_valid_s1 pulse.
- A stall (bit_valid_s1 low) holds all state and outputs; no timeout.

## Configuration
- COEF_EXTEND_EN defined: coeff_s1 follows the JPEG extend rule.
  - If raw[S-1] = 1, the value is raw zero-extended.
  - Otherwise the value is raw - (2^S - 1).
- COEF_EXTEND_EN undefined: coeff_s1 = raw zero-extended to 12 bits; sign recovery is done downstream.

## Test plan
- Reset: hold reset_s1 for 3 cycles mid-COEF -> next cycle state is IDLE, every output 0, bit_ready_s1 = 0.
- DC symbol:
  - Setup: DC maxcode[len 2] = 9'h002, base = 6'h05, table2[7] = {run 0, size 3}; start_s1, then bits 1,0 followed by 1,0,1.
  - Response: t2_addr_s1 = 7; coeff_valid_s1 with coeff_s1 = 5 on cycle 9.
  - Negative variant: bits 0,1,0 give coeff_s1 = -5 with COEF_EXTEND_EN defined, and 2 without it.
- AC EOB: after the DC symbol, an AC code mapping to {0,0} -> eob_s1 pulse, no coeff_valid_s1, state IDLE, pos ignored.
- No match: all maxcode entries set to 9'h100, feed 8 bits -> err_s1 = 1 after the 8th CMP; further bit_valid_s1 ignored; start_s1 clears err_s1.
- Stall: drop bit_valid_s1 for 5 cycles inside COEF -> latency grows by exactly 5 and the emitted value is unchanged.
- Block fill: a DC symbol followed by 21 AC symbols with run = 2 (pos 1 -> 64) -> the final coeff_valid_s1 and eob_s1 fire together; no further bit_ready_s1 until the next start_s1.
